// File: rtl/alu_bit_serializer.sv
// Bit-serial driver for a 1-bit ALU cell: shifts two operands out LSB-first,
// collects the cell's output bits and returns the assembled result with a zero flag.
module alu_bit_serializer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             cell_a,
    output logic             cell_b,
    input  logic             cell_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  sh_a_q, sh_a_d;
    logic [WIDTH-1:0]  sh_b_q, sh_b_d;
    logic [WIDTH-1:0]  res_q, res_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic              zero_q, zero_d;
    logic              valid_q, valid_d;
    logic [WIDTH-1:0]  res_next;

    // Cell output enters at the MSB so bit 0 lands at position 0 after WIDTH shifts.
    assign res_next = {cell_out, res_q[WIDTH-1:1]};

    always_comb begin
        state_d  = state_q;
        sh_a_d   = sh_a_q;
        sh_b_d   = sh_b_q;
        res_d    = res_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        zero_d   = zero_q;
        valid_d  = valid_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    sh_a_d  = in_a;
                    sh_b_d  = in_b;
                    res_d   = '0;
                    cnt_d   = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                res_d  = res_next;
                sh_a_d = {1'b0, sh_a_q[WIDTH-1:1]};
                sh_b_d = {1'b0, sh_b_q[WIDTH-1:1]};
                cnt_d  = cnt_q + CntW'(1);
                if (cnt_q == LastCnt) begin
                    state_d  = StDone;
                    result_d = res_next;
                    zero_d   = (res_next == '0);
                    valid_d  = 1'b1;
                end
            end
            StDone: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            sh_a_q   <= '0;
            sh_b_q   <= '0;
            res_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            sh_a_q   <= sh_a_d;
            sh_b_q   <= sh_b_d;
            res_q    <= res_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            valid_q  <= valid_d;
        end
    end

    // Cell inputs come straight from registers, gated to zero outside SHIFT.
    assign in_ready   = (state_q == StIdle);
    assign cell_a     = (state_q == StShift) & sh_a_q[0];
    assign cell_b     = (state_q == StShift) & sh_b_q[0];
    assign out_valid  = valid_q;
    assign out_result = result_q;
    assign out_zero   = zero_q;

endmodule

// File: tb/tb_alu_bit_serializer.sv
// Randomized self-checking bench for alu_bit_serializer with a selectable
// AND/OR/XOR cell and a word-level reference model.
module tb_alu_bit_serializer;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         cell_a;
    logic         cell_b;
    logic         cell_out;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_result;
    logic         out_zero;
    logic [1:0]   op;

    int n_cmp = 0;
    int n_err = 0;

    alu_bit_serializer #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .cell_a     (cell_a),
        .cell_b     (cell_b),
        .cell_out   (cell_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_zero   (out_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External 1-bit cell.
    always_comb begin
        case (op)
            2'd1:    cell_out = cell_a | cell_b;
            2'd2:    cell_out = cell_a ^ cell_b;
            default: cell_out = cell_a & cell_b;
        endcase
    end

    function automatic logic [W-1:0] ref_fn(input logic [1:0] f, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        case (f)
            2'd1:    return a | b;
            2'd2:    return a ^ b;
            default: return a & b;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Entered and left at a negedge with the DUT idle.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input int hold,
                         input bit isolate);
        logic [W-1:0] exp;
        exp = ref_fn(op, a, b);
        check("idle_ready", in_ready, 1);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        @(negedge clk);
        in_valid = 1'($urandom_range(0, 1));
        in_a     = W'($urandom);
        in_b     = W'($urandom);
        for (int i = 0; i < W; i++) begin
            check("shift_ready", in_ready, 0);
            check("shift_valid", out_valid, 0);
            check("cell_a_bit", cell_a, a[i]);
            check("cell_b_bit", cell_b, b[i]);
            out_ready = 1'($urandom_range(0, 1));
            if (isolate && i == W / 2) begin
                in_a = '0;
                in_b = '0;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("done_valid", out_valid, 1);
        check("done_result", out_result, exp);
        check("done_zero", out_zero, exp == '0);
        check("done_ready", in_ready, 0);
        check("done_cell_a", cell_a, 0);
        check("done_cell_b", cell_b, 0);
        out_ready = (hold == 0);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check("hold_valid", out_valid, 1);
            check("hold_result", out_result, exp);
            check("hold_zero", out_zero, exp == '0);
            check("hold_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("release_valid", out_valid, 0);
        check("release_ready", in_ready, 1);
        check("release_result_kept", out_result, exp);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        op        = 2'd0;
        @(negedge clk);
        @(negedge clk);
        check("rst_ready", in_ready, 1);
        check("rst_valid", out_valid, 0);
        check("rst_result", out_result, 0);
        check("rst_zero", out_zero, 0);
        check("rst_cell_a", cell_a, 0);
        check("rst_cell_b", cell_b, 0);
        rst = 1'b0;
        @(negedge clk);

        do_op(8'hF0, 8'h3C, 0, 1'b0);
        do_op(8'h0F, 8'hF0, 0, 1'b0);
        do_op(8'h01, 8'h01, 0, 1'b0);
        do_op(8'hA5, 8'h5A, 5, 1'b0);
        do_op(8'hFF, 8'hFF, 0, 1'b1);

        // Reset during the third SHIFT cycle discards the operation.
        in_valid = 1'b1;
        in_a     = 8'hFF;
        in_b     = 8'hFF;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_ready", in_ready, 1);
        check("midrst_cell_a", cell_a, 0);
        check("midrst_cell_b", cell_b, 0);
        check("midrst_valid", out_valid, 0);
        for (int i = 0; i < 2 * W; i++) begin
            @(negedge clk);
            check("midrst_no_pulse", out_valid, 0);
        end
        do_op(8'hAA, 8'hFF, 0, 1'b0);

        // Reset wins over a simultaneous handshake.
        rst      = 1'b1;
        in_valid = 1'b1;
        in_a     = 8'h55;
        in_b     = 8'h55;
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        check("rst_hs_ready", in_ready, 1);
        check("rst_hs_cell_a", cell_a, 0);
        @(negedge clk);
        check("rst_hs_still_idle", in_ready, 1);
        check("rst_hs_valid", out_valid, 0);

        for (int t = 0; t < 40; t++) begin
            op = 2'($urandom_range(0, 2));
            do_op(W'($urandom), W'($urandom), int'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
